// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the 16-bit RISC core control path.
//   - Instruction opcode (instr[15:13]) and op (instr[12:11]) values.
//   - nsel one-hot register-field selects and vsel writeback sources.
//   - ctrl_t: the bundle of every strobe the controller drives.
package cpu_pkg;

  // Width needed by the controller state register.
  localparam int unsigned CTRL_STATE_W = 5;

  // opcode field
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // op field
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;

  // Register-field select: [2]=Rn [1]=Rd [0]=Rm
  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;

  // Writeback source
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  typedef struct packed {
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       write;
    logic       loadir;
    logic       loadpc;
    logic       reset_pc;
    logic       load_addr;
    logic       msel;
    logic       mread;
    logic       mwrite;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/cpu_controller.sv
// cpu_controller: Moore control FSM of the 16-bit RISC core. Sequences
// fetch, PC update, decode, execute and writeback for one instruction at
// a time; all outputs are decoded from the registered state only.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   opcode, op        instr[15:13], instr[12:11] from the decoder
//   nsel, vsel        register-field select (one-hot/zero), writeback source
//   loada..loads      datapath A/B/C/status enables
//   asel, bsel        A forced to 0, B = sximm5
//   write             register-file write enable
//   loadir            latch memory read data into IR
//   loadpc, reset_pc  PC enable; reset_pc selects PC<=0 instead of PC+1
//   load_addr         latch datapath_out[8:0] into data-address register
//   msel, mread, mwrite  memory address select and commands
//   halted            FSM parked in HALT
//
// Build option: CPU_CTRL_HALT_EN adds the HALT state for opcode 111;
// without it opcode 111 is a NOP and halted is constant 0.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int unsigned STATE_W = CTRL_STATE_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write,
  output logic       loadir,
  output logic       loadpc,
  output logic       reset_pc,
  output logic       load_addr,
  output logic       msel,
  output logic       mread,
  output logic       mwrite,
  output logic       halted
);

  // The execute step is split into three states (MOV/MVN, ADD/AND, CMP)
  // because their strobes differ and outputs depend on state alone.
  typedef enum logic [STATE_W-1:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC,
    S_WIMM,
    S_GETA, S_GETB, S_EXMOV, S_EXALU, S_EXCMP, S_WRC,
    S_ADDR, S_LDA, S_MRD, S_MWB,
    S_SGETB, S_SEXE, S_MWR
`ifdef CPU_CTRL_HALT_EN
    , S_HALT
`endif
  } state_e;

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      S_RST: begin
        ctrl.loadpc   = 1'b1;
        ctrl.reset_pc = 1'b1;
        state_d       = S_IF1;
      end
      S_IF1: begin
        ctrl.mread = 1'b1;
        state_d    = S_IF2;
      end
      S_IF2: begin
        ctrl.mread  = 1'b1;
        ctrl.loadir = 1'b1;
        state_d     = S_UPC;
      end
      S_UPC: begin
        ctrl.loadpc = 1'b1;
        state_d     = S_DEC;
      end
      S_DEC: begin
        case ({opcode, op})
          {OPC_MOV, OP_MOV_IMM}:                 state_d = S_WIMM;
          {OPC_MOV, OP_MOV_REG}, {OPC_ALU, OP_MVN}: state_d = S_GETB;
          {OPC_ALU, OP_ADD}, {OPC_ALU, OP_AND}, {OPC_ALU, OP_CMP},
          {OPC_LDR, OP_MEM}, {OPC_STR, OP_MEM}:  state_d = S_GETA;
          default:                               state_d = S_IF1;
        endcase
`ifdef CPU_CTRL_HALT_EN
        if (opcode == OPC_HALT) state_d = S_HALT;
`endif
      end
      S_WIMM: begin
        ctrl.nsel  = NSEL_RN;
        ctrl.vsel  = VSEL_IMM;
        ctrl.write = 1'b1;
        state_d    = S_IF1;
      end
      S_GETA: begin
        ctrl.nsel  = NSEL_RN;
        ctrl.loada = 1'b1;
        state_d    = (opcode == OPC_LDR || opcode == OPC_STR) ? S_ADDR : S_GETB;
      end
      S_GETB: begin
        ctrl.nsel  = NSEL_RM;
        ctrl.loadb = 1'b1;
        if (opcode == OPC_MOV || op == OP_MVN) state_d = S_EXMOV;
        else if (op == OP_CMP)                 state_d = S_EXCMP;
        else                                   state_d = S_EXALU;
      end
      S_EXMOV: begin
        ctrl.asel  = 1'b1;
        ctrl.loadc = 1'b1;
        state_d    = S_WRC;
      end
      S_EXALU: begin
        ctrl.loadc = 1'b1;
        state_d    = S_WRC;
      end
      S_EXCMP: begin
        ctrl.loads = 1'b1;
        state_d    = S_IF1;
      end
      S_WRC: begin
        ctrl.nsel  = NSEL_RD;
        ctrl.vsel  = VSEL_C;
        ctrl.write = 1'b1;
        state_d    = S_IF1;
      end
      S_ADDR: begin
        ctrl.bsel  = 1'b1;
        ctrl.loadc = 1'b1;
        state_d    = S_LDA;
      end
      S_LDA: begin
        ctrl.load_addr = 1'b1;
        state_d        = (opcode == OPC_STR) ? S_SGETB : S_MRD;
      end
      S_MRD: begin
        ctrl.msel  = 1'b1;
        ctrl.mread = 1'b1;
        state_d    = S_MWB;
      end
      S_MWB: begin
        ctrl.msel  = 1'b1;
        ctrl.mread = 1'b1;
        ctrl.nsel  = NSEL_RD;
        ctrl.vsel  = VSEL_MDATA;
        ctrl.write = 1'b1;
        state_d    = S_IF1;
      end
      S_SGETB: begin
        ctrl.nsel  = NSEL_RD;
        ctrl.loadb = 1'b1;
        state_d    = S_SEXE;
      end
      S_SEXE: begin
        ctrl.asel  = 1'b1;
        ctrl.loadc = 1'b1;
        state_d    = S_MWR;
      end
      S_MWR: begin
        ctrl.msel   = 1'b1;
        ctrl.mwrite = 1'b1;
        state_d     = S_IF1;
      end
`ifdef CPU_CTRL_HALT_EN
      S_HALT: begin
        ctrl.halted = 1'b1;
        state_d     = S_HALT;
      end
`endif
      default: state_d = S_RST;
    endcase
  end

  assign nsel      = ctrl.nsel;
  assign vsel      = ctrl.vsel;
  assign loada     = ctrl.loada;
  assign loadb     = ctrl.loadb;
  assign loadc     = ctrl.loadc;
  assign loads     = ctrl.loads;
  assign asel      = ctrl.asel;
  assign bsel      = ctrl.bsel;
  assign write     = ctrl.write;
  assign loadir    = ctrl.loadir;
  assign loadpc    = ctrl.loadpc;
  assign reset_pc  = ctrl.reset_pc;
  assign load_addr = ctrl.load_addr;
  assign msel      = ctrl.msel;
  assign mread     = ctrl.mread;
  assign mwrite    = ctrl.mwrite;
  assign halted    = ctrl.halted;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: the stimulus process drives reset and the
// decoded instruction fields and queues the output row expected for each
// upcoming cycle; a monitor pops and compares one row per falling edge.
// Row layout: {nsel[2:0], vsel[1:0], loada, loadb, loadc, loads, asel,
// bsel, write, loadir, loadpc, reset_pc, load_addr, msel, mread, mwrite,
// halted}.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic loada, loadb, loadc, loads, asel, bsel, write, loadir;
  logic loadpc, reset_pc, load_addr, msel, mread, mwrite, halted;

  cpu_controller #(.STATE_W(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op),
    .nsel(nsel), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .write(write), .loadir(loadir),
    .loadpc(loadpc), .reset_pc(reset_pc), .load_addr(load_addr),
    .msel(msel), .mread(mread), .mwrite(mwrite), .halted(halted)
  );

  always #5 clk = ~clk;

  localparam logic [19:0] N_RN      = 20'h80000;
  localparam logic [19:0] N_RD      = 20'h40000;
  localparam logic [19:0] N_RM      = 20'h20000;
  localparam logic [19:0] V_IMM     = 20'h08000;
  localparam logic [19:0] V_MDATA   = 20'h18000;
  localparam logic [19:0] F_LOADA   = 20'h04000;
  localparam logic [19:0] F_LOADB   = 20'h02000;
  localparam logic [19:0] F_LOADC   = 20'h01000;
  localparam logic [19:0] F_LOADS   = 20'h00800;
  localparam logic [19:0] F_ASEL    = 20'h00400;
  localparam logic [19:0] F_BSEL    = 20'h00200;
  localparam logic [19:0] F_WRITE   = 20'h00100;
  localparam logic [19:0] F_LOADIR  = 20'h00080;
  localparam logic [19:0] F_LOADPC  = 20'h00040;
  localparam logic [19:0] F_RESETPC = 20'h00020;
  localparam logic [19:0] F_LDADDR  = 20'h00010;
  localparam logic [19:0] F_MSEL    = 20'h00008;
  localparam logic [19:0] F_MREAD   = 20'h00004;
  localparam logic [19:0] F_MWRITE  = 20'h00002;
  localparam logic [19:0] F_HALTED  = 20'h00001;

  localparam logic [19:0] R_RST   = F_LOADPC | F_RESETPC;
  localparam logic [19:0] R_IF1   = F_MREAD;
  localparam logic [19:0] R_IF2   = F_MREAD | F_LOADIR;
  localparam logic [19:0] R_UPC   = F_LOADPC;
  localparam logic [19:0] R_DEC   = 20'h00000;
  localparam logic [19:0] R_WIMM  = N_RN | V_IMM | F_WRITE;
  localparam logic [19:0] R_GETA  = N_RN | F_LOADA;
  localparam logic [19:0] R_GETB  = N_RM | F_LOADB;
  localparam logic [19:0] R_EXMOV = F_ASEL | F_LOADC;
  localparam logic [19:0] R_EXALU = F_LOADC;
  localparam logic [19:0] R_EXCMP = F_LOADS;
  localparam logic [19:0] R_WRC   = N_RD | F_WRITE;
  localparam logic [19:0] R_ADDR  = F_BSEL | F_LOADC;
  localparam logic [19:0] R_LDA   = F_LDADDR;
  localparam logic [19:0] R_MRD   = F_MSEL | F_MREAD;
  localparam logic [19:0] R_MWB   = F_MSEL | F_MREAD | N_RD | V_MDATA | F_WRITE;
  localparam logic [19:0] R_SGETB = N_RD | F_LOADB;
  localparam logic [19:0] R_SEXE  = F_ASEL | F_LOADC;
  localparam logic [19:0] R_MWR   = F_MSEL | F_MWRITE;
  localparam logic [19:0] R_HALT  = F_HALTED;

  typedef struct {
    string       name;
    logic [19:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [19:0] act;
  assign act = {nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write,
                loadir, loadpc, reset_pc, load_addr, msel, mread, mwrite, halted};

  // Monitor: one expected row per cycle while rows are pending.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s: outputs actual=%05h required=%05h", e.name, act, e.v);
      end
    end
  end

  task automatic expect_row(input string nm, input logic [19:0] v);
    exp_t e;
    e.name = nm;
    e.v    = v;
    sb_q.push_back(e);
  endtask

  task automatic fetch(input logic [15:0] ir, input string nm);
    opcode = ir[15:13];
    op     = ir[12:11];
    expect_row({nm, ".if1"}, R_IF1);
    expect_row({nm, ".if2"}, R_IF2);
    expect_row({nm, ".upc"}, R_UPC);
    expect_row({nm, ".dec"}, R_DEC);
  endtask

  // Wait (bounded) until the monitor has consumed every queued row.
  task automatic drain();
    int unsigned budget;
    budget = sb_q.size() + 4;
    while (sb_q.size() != 0 && budget != 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: rows left actual=%0d required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    reset  = 1'b1;
    opcode = 3'b000;
    op     = 2'b00;
    repeat (2) @(posedge clk);
    #2;
    expect_row("reset", R_RST);
    reset = 1'b0;
    drain(); sync();

    // MOV R0,#7
    fetch(16'hD007, "movi");
    expect_row("movi.wimm", R_WIMM);
    drain(); sync();

    // ADD R2,R0,R1
    fetch(16'hA041, "add");
    expect_row("add.geta", R_GETA);
    expect_row("add.getb", R_GETB);
    expect_row("add.exec", R_EXALU);
    expect_row("add.wrc",  R_WRC);
    drain(); sync();

    // CMP R0,R1
    fetch(16'hA801, "cmp");
    expect_row("cmp.geta", R_GETA);
    expect_row("cmp.getb", R_GETB);
    expect_row("cmp.exec", R_EXCMP);
    drain(); sync();

    // AND R2,R0,R1
    fetch(16'hB041, "and");
    expect_row("and.geta", R_GETA);
    expect_row("and.getb", R_GETB);
    expect_row("and.exec", R_EXALU);
    expect_row("and.wrc",  R_WRC);
    drain(); sync();

    // MOV R2,R1
    fetch(16'hC041, "movr");
    expect_row("movr.getb", R_GETB);
    expect_row("movr.exec", R_EXMOV);
    expect_row("movr.wrc",  R_WRC);
    drain(); sync();

    // MVN R1,R0
    fetch(16'hB820, "mvn");
    expect_row("mvn.getb", R_GETB);
    expect_row("mvn.exec", R_EXMOV);
    expect_row("mvn.wrc",  R_WRC);
    drain(); sync();

    // LDR R3,[R0,#1]
    fetch(16'h6061, "ldr");
    expect_row("ldr.geta", R_GETA);
    expect_row("ldr.addr", R_ADDR);
    expect_row("ldr.lda",  R_LDA);
    expect_row("ldr.mrd",  R_MRD);
    expect_row("ldr.mwb",  R_MWB);
    drain(); sync();

    // STR R3,[R0,#2]
    fetch(16'h8062, "str");
    expect_row("str.geta",  R_GETA);
    expect_row("str.addr",  R_ADDR);
    expect_row("str.lda",   R_LDA);
    expect_row("str.sgetb", R_SGETB);
    expect_row("str.sexe",  R_SEXE);
    expect_row("str.mwr",   R_MWR);
    drain(); sync();

    // Undefined encoding 011/01 behaves as NOP
    fetch(16'h6800, "undef");
    drain(); sync();

    // Reset asserted during EXEC of an ADD
    fetch(16'hA041, "rstmid");
    expect_row("rstmid.geta", R_GETA);
    expect_row("rstmid.getb", R_GETB);
    expect_row("rstmid.exec", R_EXALU);
    drain();
    reset = 1'b1;
    sync();
    expect_row("rstmid.rst", R_RST);
    reset = 1'b0;
    drain(); sync();

`ifdef CPU_CTRL_HALT_EN
    fetch(16'hE000, "halt");
    for (int i = 0; i < 20; i++) expect_row("halt.hold", R_HALT);
    drain();
    reset = 1'b1;
    sync();
    expect_row("halt.rst", R_RST);
    reset = 1'b0;
    drain(); sync();
`else
    fetch(16'hE000, "op111nop");
    drain(); sync();
`endif

    // After the last instruction the FSM is back in IF1
    opcode = 3'b110;
    op     = 2'b10;
    expect_row("end.if1", R_IF1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
